binarize_scan: RTL and testbench

BINARIZE_SCAN -- requirements
Module: binarize_scan

---
 rtl/binarize_scan_pkg.sv | 17 +
 rtl/binarize_cmp.sv | 57 +++++
 rtl/binarize_scan.sv | 133 +++++++++++++
 tb/tb_binarize_scan.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/binarize_scan_pkg.sv
// Shared definitions for the binarize_scan frame thresholder: FSM encoding,
// default geometry and pipeline flush length.
package binarize_scan_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam int ADDR_W_DEF  = 14;
    localparam int PIX_W_DEF   = 8;
    localparam int NUM_PIX_DEF = 16384;
    localparam int DRAIN_LEN   = 2;

endpackage

// File: rtl/binarize_cmp.sv
// Registered compare stage: pixel against offset-reduced local threshold,
// polarity applied, address and strobe carried alongside the result.
module binarize_cmp #(
    parameter int ADDR_W = 14,
    parameter int PIX_W  = 8,
    parameter int OFFSET = 0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              vld_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [PIX_W-1:0]  pix_i,
    input  logic [PIX_W-1:0]  thr_i,
    input  logic              invert_i,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic              wr_data_o
);

    localparam logic [PIX_W:0] OFF_C = (PIX_W+1)'(OFFSET);

    // Extra MSB keeps the subtraction free of wrap before the clamp to zero.
    function automatic logic [PIX_W:0] eff_thr(input logic [PIX_W-1:0] thr);
        logic [PIX_W:0] ext;
        ext = {1'b0, thr};
        if (ext < OFF_C) return '0;
        return ext - OFF_C;
    endfunction

    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic              wr_data_q;
    logic              wr_data_d;

    always_comb begin
        wr_data_d = ({1'b0, pix_i} > eff_thr(thr_i)) ^ invert_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= 1'b0;
        end else begin
            wr_en_q <= vld_i;
            if (vld_i) begin
                wr_addr_q <= addr_i;
                wr_data_q <= wr_data_d;
            end
        end
    end

    assign wr_en_o   = wr_en_q;
    assign wr_addr_o = wr_addr_q;
    assign wr_data_o = wr_data_q;

endmodule

// File: rtl/binarize_scan.sv
// Frame scanner: walks both ROMs with one shared address, binarizes each
// pixel against its local threshold and writes the result to an output RAM.
module binarize_scan
    import binarize_scan_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int PIX_W   = PIX_W_DEF,
    parameter int NUM_PIX = NUM_PIX_DEF,
    parameter int OFFSET  = 0
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic              invert,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [PIX_W-1:0]  pix_q,
    input  logic [PIX_W-1:0]  thr_q,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              wr_data,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   white_count
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIX - 1);
    localparam logic [ADDR_W:0]   MAX_CNT   = (ADDR_W+1)'(NUM_PIX);
    localparam logic [1:0]        DRAIN_END = 2'(DRAIN_LEN - 1);

    state_e            state_q;
    logic [ADDR_W-1:0] rd_addr_q;
    logic              issue_q;
    logic [1:0]        drain_q;
    logic              busy_q;
    logic              done_q;
    logic              inv_q;
    logic              vld_p1_q;
    logic [ADDR_W-1:0] addr_p1_q;
    logic [ADDR_W:0]   white_q;
    logic [ADDR_W:0]   white_d;

    // issue_q marks cycles whose rd_addr is a real read; the address holds
    // at the last pixel for one cycle after the final issue instead of wrapping.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            rd_addr_q <= '0;
            issue_q   <= 1'b0;
            drain_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            inv_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q   <= RUN;
                        rd_addr_q <= '0;
                        issue_q   <= 1'b1;
                        inv_q     <= invert;
                        busy_q    <= 1'b1;
                    end
                end
                RUN: begin
                    if (issue_q) begin
                        if (rd_addr_q == LAST_ADDR) issue_q <= 1'b0;
                        else rd_addr_q <= rd_addr_q + 1'b1;
                    end else begin
                        state_q <= DRAIN;
                        drain_q <= '0;
                    end
                end
                DRAIN: begin
                    if (drain_q == DRAIN_END) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        drain_q <= drain_q + 1'b1;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // ROM read latency stage
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vld_p1_q  <= 1'b0;
            addr_p1_q <= '0;
        end else begin
            vld_p1_q  <= issue_q;
            addr_p1_q <= rd_addr_q;
        end
    end

    binarize_cmp #(
        .ADDR_W (ADDR_W),
        .PIX_W  (PIX_W),
        .OFFSET (OFFSET)
    ) u_cmp (
        .clk_i     (clock),
        .rst_ni    (reset_n),
        .vld_i     (vld_p1_q),
        .addr_i    (addr_p1_q),
        .pix_i     (pix_q),
        .thr_i     (thr_q),
        .invert_i  (inv_q),
        .wr_en_o   (wr_en),
        .wr_addr_o (wr_addr),
        .wr_data_o (wr_data)
    );

    always_comb begin
        white_d = white_q;
        if (state_q == IDLE && start) white_d = '0;
        else if (wr_en && wr_data && white_q != MAX_CNT) white_d = white_q + 1'b1;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) white_q <= '0;
        else          white_q <= white_d;
    end

    assign rd_addr     = rd_addr_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign white_count = white_q;

endmodule

// File: tb/tb_binarize_scan.sv
// Bench: a 16-pixel instance for timing/polarity and a full 128x128 instance
// with offset for saturation, mid-frame reset and whole-frame coverage.
module tb_binarize_scan;

    typedef struct {
        int   addr;
        logic d;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    endtask

    // small instance: 16 pixels, OFFSET 0
    logic       rst_s_n, start_s, invert_s;
    logic [3:0] rd_addr_s, wr_addr_s;
    logic [7:0] pix_s, thr_s;
    logic       wr_en_s, wr_data_s, busy_s, done_s;
    logic [4:0] white_s;

    binarize_scan #(.ADDR_W(4), .PIX_W(8), .NUM_PIX(16), .OFFSET(0)) dut_s (
        .clock(clk), .reset_n(rst_s_n), .start(start_s), .invert(invert_s),
        .rd_addr(rd_addr_s), .pix_q(pix_s), .thr_q(thr_s),
        .wr_en(wr_en_s), .wr_addr(wr_addr_s), .wr_data(wr_data_s),
        .busy(busy_s), .done(done_s), .white_count(white_s)
    );

    always @(posedge clk) begin
        pix_s <= {rd_addr_s, 4'h0};
        thr_s <= 8'h80;
    end

    // full instance: 16384 pixels, OFFSET 0x10
    logic        rst_f_n, start_f, invert_f;
    logic [13:0] rd_addr_f, wr_addr_f;
    logic [7:0]  pix_f, thr_f;
    logic        wr_en_f, wr_data_f, busy_f, done_f;
    logic [14:0] white_f;

    binarize_scan #(.ADDR_W(14), .PIX_W(8), .NUM_PIX(16384), .OFFSET(16)) dut_f (
        .clock(clk), .reset_n(rst_f_n), .start(start_f), .invert(invert_f),
        .rd_addr(rd_addr_f), .pix_q(pix_f), .thr_q(thr_f),
        .wr_en(wr_en_f), .wr_addr(wr_addr_f), .wr_data(wr_data_f),
        .busy(busy_f), .done(done_f), .white_count(white_f)
    );

    function automatic logic [7:0] f_pix(input int a);
        if (a == 0) return 8'h00;
        if (a == 1) return 8'h01;
        return 8'((a * 37) ^ (a >> 6));
    endfunction

    function automatic logic [7:0] f_thr(input int a);
        if (a < 2) return 8'h05;
        return 8'((a * 11) + (a >> 7));
    endfunction

    function automatic logic f_exp(input int a);
        int p, t;
        p = int'(f_pix(a));
        t = int'(f_thr(a)) - 16;
        if (t < 0) t = 0;
        return p > t;
    endfunction

    always @(posedge clk) begin
        pix_f <= f_pix(int'(rd_addr_f));
        thr_f <= f_thr(int'(rd_addr_f));
    end

    exp_t q_s[$];
    exp_t q_f[$];
    int   t0_s, first_wr_s;
    int   wr_cnt_f, last_addr_f;
    logic d0_f, d1_f, wrap_f;
    logic [13:0] prev_rd_f;

    always @(negedge clk) begin
        exp_t e;
        if (wr_en_s) begin
            if (first_wr_s < 0) first_wr_s = cyc - t0_s;
            if (q_s.size() == 0) chk("s_extra_write", wr_addr_s, -1);
            else begin
                e = q_s.pop_front();
                chk("s_wr_addr", wr_addr_s, e.addr);
                chk("s_wr_data", wr_data_s, e.d);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (busy_f && prev_rd_f != 14'd0 && rd_addr_f == 14'd0) wrap_f = 1'b1;
        prev_rd_f = rd_addr_f;
        if (wr_en_f) begin
            wr_cnt_f++;
            last_addr_f = int'(wr_addr_f);
            if (wr_addr_f == 14'd0) d0_f = wr_data_f;
            if (wr_addr_f == 14'd1) d1_f = wr_data_f;
            if (q_f.size() == 0) chk("f_extra_write", wr_addr_f, -1);
            else begin
                e = q_f.pop_front();
                if (wr_addr_f != 14'(e.addr)) chk("f_wr_addr", wr_addr_f, e.addr);
                else if (wr_data_f != e.d) chk("f_wr_data", wr_data_f, e.d);
                else chk("f_write", 1, 1 - int'(wr_addr_f != 14'(e.addr)));
            end
        end
    end

    task automatic run_small(input logic inv, input int exp_white);
        int k;
        @(negedge clk);
        invert_s = inv;
        start_s  = 1'b1;
        t0_s = cyc;
        first_wr_s = -1;
        for (int a = 0; a < 16; a++) q_s.push_back('{a, logic'((a * 16 > 128) ^ inv)});
        @(negedge clk);
        start_s  = 1'b0;
        invert_s = ~inv;
        chk("s_busy_run", busy_s, 1);
        chk("s_rd_addr_first", rd_addr_s, 0);
        repeat (4) @(negedge clk);
        start_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        k = 0;
        while (!done_s && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("s_done_seen", done_s, 1);
        chk("s_done_latency", cyc - t0_s, 16 + 4);
        chk("s_first_wr_latency", first_wr_s, 3);
        chk("s_busy_at_done", busy_s, 0);
        chk("s_white", white_s, exp_white);
        start_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        chk("s_done_pulse", done_s, 0);
        repeat (3) @(negedge clk);
        chk("s_busy_after_done_start", busy_s, 0);
        chk("s_white_hold", white_s, exp_white);
        chk("s_queue_empty", q_s.size(), 0);
    endtask

    initial begin
        int k, exp_white;
        rst_s_n = 1'b0; start_s = 1'b0; invert_s = 1'b0;
        rst_f_n = 1'b0; start_f = 1'b0; invert_f = 1'b0;
        wr_cnt_f = 0; last_addr_f = -1; d0_f = 1'bx; d1_f = 1'bx;
        wrap_f = 1'b0; prev_rd_f = '0; first_wr_s = -1; t0_s = 0;
        repeat (3) @(negedge clk);
        chk("rst_s_busy", busy_s, 0);
        chk("rst_s_wr_en", wr_en_s, 0);
        chk("rst_s_white", white_s, 0);
        chk("rst_f_done", done_f, 0);
        chk("rst_f_rd_addr", rd_addr_f, 0);
        rst_s_n = 1'b1;
        rst_f_n = 1'b1;
        @(negedge clk);

        run_small(1'b0, 7);
        run_small(1'b1, 9);

        // abort a full frame with reset at pixel 7
        @(negedge clk);
        start_f = 1'b1;
        for (int a = 0; a < 16384; a++) q_f.push_back('{a, f_exp(a)});
        @(negedge clk);
        start_f = 1'b0;
        k = 0;
        while (rd_addr_f != 14'd7 && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("f_reached_pix7", rd_addr_f, 7);
        rst_f_n = 1'b0;
        #1;
        chk("f_rst_rd_addr", rd_addr_f, 0);
        chk("f_rst_wr_en", wr_en_f, 0);
        chk("f_rst_wr_addr", wr_addr_f, 0);
        chk("f_rst_wr_data", wr_data_f, 0);
        chk("f_rst_busy", busy_f, 0);
        chk("f_rst_done", done_f, 0);
        chk("f_rst_white", white_f, 0);
        q_f.delete();
        repeat (2) @(negedge clk);
        rst_f_n = 1'b1;
        wr_cnt_f = 0;
        repeat (20) @(negedge clk);
        chk("f_no_write_after_rst", wr_cnt_f, 0);
        chk("f_idle_after_rst", busy_f, 0);

        // complete frame
        exp_white = 0;
        @(negedge clk);
        start_f = 1'b1;
        for (int a = 0; a < 16384; a++) begin
            q_f.push_back('{a, f_exp(a)});
            if (f_exp(a)) exp_white++;
        end
        wr_cnt_f = 0;
        wrap_f = 1'b0;
        @(negedge clk);
        start_f = 1'b0;
        k = 0;
        while (!done_f && k < 17000) begin
            @(negedge clk);
            k++;
        end
        chk("f_done_seen", done_f, 1);
        chk("f_write_count", wr_cnt_f, 16384);
        chk("f_last_addr", last_addr_f, 16383);
        chk("f_queue_empty", q_f.size(), 0);
        chk("f_white", white_f, exp_white);
        chk("f_no_wrap", wrap_f, 0);
        chk("f_rd_addr_allones", rd_addr_f, 16383);
        chk("f_sat_pix0", d0_f, 0);
        chk("f_sat_pix1", d1_f, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
